rgb_fader: RTL

- Sits directly upstream of the three per-channel 8-bit PWM generators and drives their duty-cycle inputs.
- Accepts a target RGB colour over a valid/ready handshake.
- Ramps each channel's duty value from its current level toward the target by a fixed step once per tick. Ticks come from an internal prescaler.
- Signals completion with a one-cycle done pulse; this lets firmware sequence colour transitions without per-step intervention.

---
 rtl/rgb_fader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rgb_fader.sv
// rgb_fader: ramps three PWM duty values toward a handshaken target colour, one STEP per prescaler tick.
// Define RGB_FADER_GAMMA_EN to add a registered gamma-correction stage on the duty outputs.
module rgb_fader #(
   parameter int unsigned TICK_DIV = 100000,
   parameter int unsigned STEP     = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic [7:0] i_red,
   input  logic [7:0] i_green,
   input  logic [7:0] i_blue,
   output logic [7:0] o_red_duty,
   output logic [7:0] o_green_duty,
   output logic [7:0] o_blue_duty,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic {
      IDLE,
      FADE
   } state_t;

   localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
   localparam logic [8:0]  STEP_9    = 9'(STEP);

   state_t      state;
   state_t      state_next;
   logic [23:0] tick_cnt;
   logic [7:0]  cur_r, cur_g, cur_b;
   logic [7:0]  tgt_r, tgt_g, tgt_b;
   logic        accept;
   logic        done_set;
   logic        done_q;
   logic        tick;
   logic        all_eq;

   // 9-bit step with clamp so a channel can neither wrap nor overshoot its target
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      logic [8:0] up;
      logic [8:0] dn;
      up = {1'b0, cur} + STEP_9;
      dn = {1'b0, cur} - STEP_9;
      if (cur < tgt)
         return (up > {1'b0, tgt}) ? tgt : up[7:0];
      else if (cur > tgt)
         return (dn[8] || (dn < {1'b0, tgt})) ? tgt : dn[7:0];
      else
         return cur;
   endfunction

   assign tick   = (tick_cnt == TICK_LAST);
   assign all_eq = (cur_r == tgt_r) && (cur_g == tgt_g) && (cur_b == tgt_b);

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done_set   = 1'b0;
      o_ready    = 1'b0;
      o_busy     = 1'b0;
      case (state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               accept     = 1'b1;
               state_next = FADE;
            end
         end
         FADE: begin
            o_busy = 1'b1;
            if (all_eq) begin
               done_set   = 1'b1;
               state_next = IDLE;
            end
         end
      endcase
   end

   // The equality check runs a cycle after the last tick, which is what yields the +1 done latency
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tick_cnt <= '0;
         cur_r    <= '0;
         cur_g    <= '0;
         cur_b    <= '0;
         tgt_r    <= '0;
         tgt_g    <= '0;
         tgt_b    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= done_set;
         if (accept) begin
            tgt_r    <= i_red;
            tgt_g    <= i_green;
            tgt_b    <= i_blue;
            tick_cnt <= '0;
         end else if (state == FADE) begin
            if (tick) begin
               tick_cnt <= '0;
               cur_r    <= step_toward(cur_r, tgt_r);
               cur_g    <= step_toward(cur_g, tgt_g);
               cur_b    <= step_toward(cur_b, tgt_b);
            end else begin
               tick_cnt <= tick_cnt + 24'd1;
            end
         end
      end
   end

`ifdef RGB_FADER_GAMMA_EN
   function automatic logic [7:0] gamma(input logic [7:0] v);
      logic [15:0] prod;
      prod = ({8'd0, v} + 16'd1) * {8'd0, v};
      return 8'(prod >> 8);
   endfunction

   // Done is delayed with the outputs so it lines up with the final corrected value
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_red_duty   <= '0;
         o_green_duty <= '0;
         o_blue_duty  <= '0;
         o_done       <= 1'b0;
      end else begin
         o_red_duty   <= gamma(cur_r);
         o_green_duty <= gamma(cur_g);
         o_blue_duty  <= gamma(cur_b);
         o_done       <= done_q;
      end
   end
`else
   assign o_red_duty   = cur_r;
   assign o_green_duty = cur_g;
   assign o_blue_duty  = cur_b;
   assign o_done       = done_q;
`endif

endmodule
